// File: rtl/gamepad_move_queue.sv
// Turns single-controller button levels into discrete 2048 game commands
// (press events plus hold-to-repeat) and buffers them in a small valid/ready FIFO.
module gamepad_move_queue #(
  parameter int REPEAT_DELAY  = 12000000,
  parameter int REPEAT_PERIOD = 3000000,
  parameter int REPEAT_EN     = 1,
  parameter int FIFO_DEPTH    = 4,
  parameter int CNT_WIDTH     = 24
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          is_present,
  input  logic                          up,
  input  logic                          down,
  input  logic                          left,
  input  logic                          right,
  input  logic                          start,
  output logic                          cmd_valid,
  output logic [2:0]                    cmd,
  input  logic                          cmd_ready,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          overflow
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  localparam logic [2:0] CMD_UP    = 3'd0;
  localparam logic [2:0] CMD_DOWN  = 3'd1;
  localparam logic [2:0] CMD_LEFT  = 3'd2;
  localparam logic [2:0] CMD_RIGHT = 3'd3;
  localparam logic [2:0] CMD_NEW   = 3'd4;
  localparam logic [2:0] DIR_NONE  = 3'd7;

  localparam logic [CNT_WIDTH-1:0] DELAY_LAST  = CNT_WIDTH'(REPEAT_DELAY - 1);
  localparam logic [CNT_WIDTH-1:0] PERIOD_LAST = CNT_WIDTH'(REPEAT_PERIOD - 1);
  localparam logic [CW-1:0]        FULL_COUNT  = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } dir_state_t;

  // Only a lone direction counts; chords and diagonals decode to NONE.
  function automatic logic [2:0] decode_dir(input logic [3:0] rldu);
    logic [2:0] d;
    case (rldu)
      4'b0001: d = CMD_UP;
      4'b0010: d = CMD_DOWN;
      4'b0100: d = CMD_LEFT;
      4'b1000: d = CMD_RIGHT;
      default: d = DIR_NONE;
    endcase
    return d;
  endfunction

  dir_state_t            state, state_n;
  logic [CNT_WIDTH-1:0]  cnt, cnt_n;
  logic [2:0]            prev_dir;
  logic                  prev_start;

  logic [2:0]            dir;
  logic                  eff_start;
  logic                  start_rise;
  logic                  dir_push;
  logic                  push;
  logic [2:0]            push_cmd;

  logic [2:0]            mem [FIFO_DEPTH];
  logic [AW-1:0]         wr_ptr, rd_ptr;
  logic [CW-1:0]         count;
  logic                  full, pop, wr_en;

  always_comb begin
    dir        = decode_dir({right & is_present, left & is_present,
                             down & is_present, up & is_present});
    eff_start  = start & is_present;
    start_rise = eff_start & ~prev_start;
  end

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    dir_push = 1'b0;
    case (state)
      ST_IDLE: begin
        if (dir != DIR_NONE) begin
          dir_push = 1'b1;
          state_n  = ST_DELAY;
          cnt_n    = '0;
        end
      end
      ST_DELAY: begin
        if (dir == DIR_NONE) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (dir != prev_dir) begin
          dir_push = 1'b1;
          cnt_n    = '0;
        end else if (REPEAT_EN != 0) begin
          if (cnt == DELAY_LAST) begin
            dir_push = 1'b1;
            state_n  = ST_REPEAT;
            cnt_n    = '0;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
      end
      ST_REPEAT: begin
        if (dir == DIR_NONE) begin
          state_n = ST_IDLE;
          cnt_n   = '0;
        end else if (dir != prev_dir) begin
          dir_push = 1'b1;
          state_n  = ST_DELAY;
          cnt_n    = '0;
        end else if (cnt == PERIOD_LAST) begin
          dir_push = 1'b1;
          cnt_n    = '0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = '0;
      end
    endcase
  end

  // NEW_GAME takes the single push slot; the FSM still advances as computed.
  always_comb begin
    push     = start_rise | dir_push;
    push_cmd = start_rise ? CMD_NEW : dir;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      cnt        <= '0;
      prev_dir   <= DIR_NONE;
      prev_start <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      prev_dir   <= dir;
      prev_start <= eff_start;
    end
  end

  always_comb begin
    full      = (count == FULL_COUNT);
    cmd_valid = (count != '0);
    pop       = cmd_valid & cmd_ready;
    wr_en     = push & (~full | pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + AW'(1);
      if (pop)   rd_ptr <= rd_ptr + AW'(1);
      case ({wr_en, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
      if (push & full & ~pop) overflow <= 1'b1;
    end
  end

  // Storage carries no reset; cmd is gated by occupancy so it still reads 0 when empty.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_ptr] <= push_cmd;
  end

  always_comb begin
    cmd        = cmd_valid ? mem[rd_ptr] : 3'd0;
    fifo_count = count;
  end

endmodule
